// File: rtl/decoder_3to8_reg.sv
// Registered binary-to-one-hot decoder.
// An IN_W-bit select code drives exactly one of 2**IN_W output lines high,
// one clock after it is sampled with en=1. A companion valid flag marks the
// cycle that follows each enabled sample.
//
// Output semantics: valid is a pure registered copy of en. There is no
// ready/back-pressure; downstream logic must take y in the cycle that valid
// is high. When valid is low, y still holds the last enabled decode
// (or zero after reset) so downstream enables stay stable.
module decoder_3to8_reg #(
  parameter int IN_W = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [IN_W-1:0]        a,
  output logic [(1<<IN_W)-1:0]   y,
  output logic                   valid
);

  // Output width follows the select width; not independently overridable.
  localparam int OUT_W = 1 << IN_W;

  logic [OUT_W-1:0] dec;

  // One-hot decode of the select code; every code in range maps to one line.
  always_comb begin
    dec    = '0;
    dec[a] = 1'b1;
  end

  // Register the decode on enabled samples; valid tracks en every cycle.
  // Reset clears both asynchronously and takes priority over the clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y     <= '0;
      valid <= 1'b0;
    end else begin
      valid <= en;
      if (en) begin
        y <= dec;
      end
    end
  end

endmodule

// File: tb/tb_decoder_3to8_reg.sv
// Directed bench for decoder_3to8_reg: default 3-to-8 build plus a 2-to-4 build.
module tb_decoder_3to8_reg;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [2:0] a;
  logic [7:0] y;
  logic       valid;

  logic       en2;
  logic [1:0] a2;
  logic [3:0] y2;
  logic       valid2;

  int checks;
  int errors;

  logic [7:0] exp8 [8];
  logic [3:0] exp4 [4];

  decoder_3to8_reg u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .a     (a),
    .y     (y),
    .valid (valid)
  );

  decoder_3to8_reg #(.IN_W(2)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en2),
    .a     (a2),
    .y     (y2),
    .valid (valid2)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    a     = 3'd0;
    en2   = 1'b0;
    a2    = 2'd0;
    #1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (y !== 8'h00) begin
        errors++;
        $display("FAIL reset_y cycle %0d: got %b expected 00000000", i, y);
      end
      checks++;
      if (valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_valid cycle %0d: got %b expected 0", i, valid);
      end
    end
  endtask

  task automatic test_sweep();
    rst_n = 1'b1;
    #1;
    checks++;
    if (y !== 8'h00 || valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_release: got y=%b valid=%b expected 00000000/0", y, valid);
    end
    for (int i = 0; i < 8; i++) begin
      a  = 3'(i);
      en = 1'b1;
      step();
      checks++;
      if (y !== exp8[i]) begin
        errors++;
        $display("FAIL sweep_y a=%0d: got %b expected %b", i, y, exp8[i]);
      end
      checks++;
      if (valid !== 1'b1) begin
        errors++;
        $display("FAIL sweep_valid a=%0d: got %b expected 1", i, valid);
      end
    end
  endtask

  task automatic test_hold();
    a  = 3'd5;
    en = 1'b1;
    step();
    checks++;
    if (y !== 8'b0010_0000) begin
      errors++;
      $display("FAIL hold_load: got %b expected 00100000", y);
    end
    en = 1'b0;
    a  = 3'd2;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (y !== 8'b0010_0000) begin
        errors++;
        $display("FAIL hold_y cycle %0d: got %b expected 00100000", i, y);
      end
      checks++;
      if (valid !== 1'b0) begin
        errors++;
        $display("FAIL hold_valid cycle %0d: got %b expected 0", i, valid);
      end
    end
  endtask

  task automatic test_async_reset();
    a  = 3'd7;
    en = 1'b1;
    step();
    checks++;
    if (y !== 8'b1000_0000 || valid !== 1'b1) begin
      errors++;
      $display("FAIL async_pre: got y=%b valid=%b expected 10000000/1", y, valid);
    end
    #2;
    a     = 3'd3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (y !== 8'h00 || valid !== 1'b0) begin
      errors++;
      $display("FAIL async_immediate: got y=%b valid=%b expected 00000000/0", y, valid);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (y !== 8'h00 || valid !== 1'b0) begin
        errors++;
        $display("FAIL async_held cycle %0d: got y=%b valid=%b expected 00000000/0", i, y, valid);
      end
    end
  endtask

  task automatic test_release();
    a     = 3'd3;
    en    = 1'b1;
    rst_n = 1'b1;
    #2;
    checks++;
    if (y !== 8'h00 || valid !== 1'b0) begin
      errors++;
      $display("FAIL release_before_edge: got y=%b valid=%b expected 00000000/0", y, valid);
    end
    step();
    checks++;
    if (y !== 8'b0000_1000 || valid !== 1'b1) begin
      errors++;
      $display("FAIL release_first_edge: got y=%b valid=%b expected 00001000/1", y, valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] seq [5];
    logic [7:0] want [5];
    seq  = '{3'd3, 3'd6, 3'd1, 3'd0, 3'd7};
    want = '{8'b0000_1000, 8'b0100_0000, 8'b0000_0010, 8'b0000_0001, 8'b1000_0000};
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a = seq[i];
      step();
      checks++;
      if (y !== want[i] || valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b step %0d a=%0d: got y=%b valid=%b expected %b/1", i, seq[i], y, valid, want[i]);
      end
    end
  endtask

  task automatic test_param_in_w2();
    checks++;
    if (y2 !== 4'b0000 || valid2 !== 1'b0) begin
      errors++;
      $display("FAIL w2_idle: got y=%b valid=%b expected 0000/0", y2, valid2);
    end
    for (int i = 0; i < 4; i++) begin
      a2  = 2'(i);
      en2 = 1'b1;
      step();
      checks++;
      if (y2 !== exp4[i] || valid2 !== 1'b1) begin
        errors++;
        $display("FAIL w2_sweep a=%0d: got y=%b valid=%b expected %b/1", i, y2, valid2, exp4[i]);
      end
    end
    en2 = 1'b0;
    step();
    checks++;
    if (y2 !== 4'b1000 || valid2 !== 1'b0) begin
      errors++;
      $display("FAIL w2_hold: got y=%b valid=%b expected 1000/0", y2, valid2);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp8 = '{8'b0000_0001, 8'b0000_0010, 8'b0000_0100, 8'b0000_1000,
             8'b0001_0000, 8'b0010_0000, 8'b0100_0000, 8'b1000_0000};
    exp4 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    test_reset();
    test_sweep();
    test_hold();
    test_async_reset();
    test_release();
    test_back_to_back();
    test_param_in_w2();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder_3to8_reg.md
Name: decoder_3to8_reg

Overview:
- Registered binary-to-one-hot decoder: an IN_W-bit select code `a` drives exactly one of 2^IN_W output lines high.
- Default build is 3-to-8.
- Used as an address/select decoder feeding downstream enables in the clocked datapath.
- Output is registered (one-cycle latency) and carries a companion valid flag.

Parameters:
- IN_W, 3, width of select input `a` (1..6 supported).
- OUT_W, 2**IN_W, output width; derived (localparam), not overridable.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset; asserts immediately, released synchronously to clk by upstream reset logic.
- en  input  1  decode enable; sampled on rising clk edge.
- a  input  IN_W  binary select code.
- y  output  OUT_W  registered one-hot decode; y[k]=1 iff last enabled sample had a==k.
- valid  output  1  registered; 1 in the cycle after an enabled sample, else 0.

Behaviour:
- Reset (rst_n=0, any time, independent of clk):
  - y forced to all zeros (8'b00000000 for default) immediately.
  - valid forced to 0.
  - Held there while rst_n=0, whatever `a`/`en` do.
- First rising clk edge after rst_n returns high is the first edge that can update state; no extra flush cycle.
- Rising clk edge, rst_n=1, en=1:
  - y <= 1 << a (zero-extended to OUT_W).
  - valid <= 1.
  - Latency: exactly one clock from sampling `a` to `y`.
- Rising clk edge, rst_n=1, en=0:
  - y holds its previous value.
  - valid <= 0.
- Mapping (default IN_W=3):
  - a=0->00000001, 1->00000010, 2->00000100, 3->00001000
  - a=4->00010000, 5->00100000, 6->01000000, 7->10000000
- Invariants:
  - After any enabled sample, y is strictly one-hot; full input range decoded, no out-of-range case exists.
  - Outside reset and before the first enabled sample, y is all zeros.
- Back-to-back enabled samples: y updates every cycle; no bubbles; valid stays 1.
- Reset mid-operation: y and valid clear asynchronously within the same cycle rst_n falls, including between clock edges. The previous decode is not retained after reset release.
- Simultaneous rst_n low and clk edge: reset wins.
- X/Z on `a` with en=1 is illegal stimulus; the design need not define y, but valid still registers en.
- No combinational path from any input to y or valid (glitch-free outputs).

Test Plan:
- Power-up: rst_n=0, en=1, a=0, toggle clk 2 cycles -> y=00000000, valid=0 throughout.
- Release and sweep: rst_n=1, en=1, apply a=0..7 on successive cycles -> one cycle after each sample y=00000001,00000010,...,10000000; valid=1 from the first post-sample cycle onward.
- Hold on disable: after a=5 enabled (y=00100000), set en=0 and change a to 2 for 3 cycles -> y stays 00100000; valid=0 from the first disabled edge.
- Asynchronous mid-op reset: with y=10000000, drop rst_n between clk edges with a=3 -> y=00000000 and valid=0 immediately (before the next edge), and they stay so for 2 edges.
- Reset release: raise rst_n with a=3, en=1 -> y remains 00000000 until the first rising edge, then y=00001000, valid=1.
- Parameter check: IN_W=2 build, sweep a=0..3 -> y=0001,0010,0100,1000 with the same one-cycle latency.
